// File: rtl/mem_addr_pkg.sv
// Shared encodings for the memory address unit and its address stepper.
package mem_addr_pkg;

  // Per-burst address stepping mode.
  typedef enum logic [1:0] {
    MODE_HOLD = 2'd0,
    MODE_INC  = 2'd1,
    MODE_DEC  = 2'd2,
    MODE_WRAP = 2'd3
  } mode_e;

  // Burst sequencer states.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/addr_step.sv
// Combinational next-address function. Shared with the program counter.
module addr_step
  import mem_addr_pkg::*;
#(
  parameter int ADDR_W = 16,
  parameter int WIN_W  = 4
) (
  input  logic [ADDR_W-1:0] addr_i,
  input  mode_e             mode_i,
  output logic [ADDR_W-1:0] addr_o
);

  // Step the address; INC/DEC wrap naturally modulo 2^ADDR_W, WRAP only
  // moves the low window bits so the upper bits stay put.
  always_comb begin
    addr_o = addr_i;
    case (mode_i)
      MODE_HOLD: addr_o = addr_i;
      MODE_INC:  addr_o = addr_i + ADDR_W'(1);
      MODE_DEC:  addr_o = addr_i - ADDR_W'(1);
      MODE_WRAP: addr_o = {addr_i[ADDR_W-1:WIN_W], addr_i[WIN_W-1:0] + WIN_W'(1)};
      default:   addr_o = addr_i;
    endcase
  end

endmodule

// File: rtl/mem_addr_unit.sv
// Memory address register with a burst sequencer and req/ack toward memory.
module mem_addr_unit
  import mem_addr_pkg::*;
#(
  parameter int ADDR_W = 16,
  parameter int LEN_W  = 8,
  parameter int WIN_W  = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic [ADDR_W-1:0] bus_in,
  input  logic [LEN_W-1:0]  len_in,
  input  logic [1:0]        mode,
  input  logic              start,
  input  logic              mem_ack,
  output logic              mem_req,
  output logic [ADDR_W-1:0] addr_out,
  output logic [LEN_W-1:0]  beats_left,
  output logic              busy,
  output logic              done
);

  state_e            state_q;
  mode_e             mode_q;
  logic [ADDR_W-1:0] addr_q;
  logic [LEN_W-1:0]  beats_q;
  logic [ADDR_W-1:0] addr_d;

  addr_step #(
    .ADDR_W (ADDR_W),
    .WIN_W  (WIN_W)
  ) u_step (
    .addr_i (addr_q),
    .mode_i (mode_q),
    .addr_o (addr_d)
  );

  // Burst FSM plus address register and beat counter. A load in the same
  // cycle as start lands in addr_q at the same edge, so the burst begins
  // from the newly loaded address without extra logic.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      mode_q  <= MODE_HOLD;
      addr_q  <= '0;
      beats_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (load) addr_q <= bus_in;
          if (start) begin
            beats_q <= len_in;
            mode_q  <= mode_e'(mode);
            state_q <= (len_in == '0) ? ST_DONE : ST_REQ;
          end
        end
        ST_REQ: begin
          if (mem_ack) begin
            addr_q  <= addr_d;
            beats_q <= beats_q - LEN_W'(1);
            if (beats_q == LEN_W'(1)) state_q <= ST_DONE;
          end
        end
        ST_DONE: state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Outputs come straight from registered state; no input-to-output path.
  assign mem_req    = (state_q == ST_REQ);
  assign busy       = (state_q != ST_IDLE);
  assign done       = (state_q == ST_DONE);
  assign addr_out   = addr_q;
  assign beats_left = beats_q;

endmodule

// File: tb/tb_mem_addr_unit.sv
// Randomized + directed bench for mem_addr_unit against an arithmetic model.
module tb_mem_addr_unit;
  localparam int ADDR_W = 16;
  localparam int LEN_W  = 8;
  localparam int WIN_W  = 4;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              load = 1'b0;
  logic [ADDR_W-1:0] bus_in = '0;
  logic [LEN_W-1:0]  len_in = '0;
  logic [1:0]        mode = '0;
  logic              start = 1'b0;
  logic              mem_ack = 1'b0;
  logic              mem_req;
  logic [ADDR_W-1:0] addr_out;
  logic [LEN_W-1:0]  beats_left;
  logic              busy;
  logic              done;

  int n_tests = 0;
  int n_fail  = 0;
  logic [ADDR_W-1:0] cur;  // model of the address register

  mem_addr_unit #(.ADDR_W(ADDR_W), .LEN_W(LEN_W), .WIN_W(WIN_W)) dut (
    .clk(clk), .reset(reset), .load(load), .bus_in(bus_in), .len_in(len_in),
    .mode(mode), .start(start), .mem_ack(mem_ack), .mem_req(mem_req),
    .addr_out(addr_out), .beats_left(beats_left), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Address after k steps from a0, straight from the stepping rules.
  function automatic logic [ADDR_W-1:0] exp_addr(input logic [ADDR_W-1:0] a0,
                                                 input int m, input int k);
    logic [WIN_W-1:0] lo;
    case (m)
      1: return a0 + ADDR_W'(k);
      2: return a0 - ADDR_W'(k);
      3: begin
        lo = a0[WIN_W-1:0] + WIN_W'(k);
        return {a0[ADDR_W-1:WIN_W], lo};
      end
      default: return a0;
    endcase
  endfunction

  // how: 0 no load, 1 load then start, 2 load+start same cycle
  // ackp: 0 ack held high, 1 toggle 1,0,1,..., 2 random
  task automatic burst(input logic [ADDR_W-1:0] a0, input int len, input int m,
                       input int how, input int ackp, input bit junk);
    int beat, cyc;
    logic [ADDR_W-1:0] base;
    if (how == 1) begin
      load = 1'b1; bus_in = a0;
      step();
      load = 1'b0;
      cur = a0;
      chk("load_addr", 32'(addr_out), 32'(a0));
      chk("load_req", 32'(mem_req), 0);
    end
    if (how == 2) begin
      load = 1'b1; bus_in = a0; cur = a0;
    end
    base = cur;
    start = 1'b1; len_in = LEN_W'(len); mode = 2'(m);
    step();
    start = 1'b0; load = 1'b0;
    beat = 0; cyc = 0;
    while (beat < len) begin
      chk("req", 32'(mem_req), 1);
      chk("busy", 32'(busy), 1);
      chk("nodone", 32'(done), 0);
      chk("beat_addr", 32'(addr_out), 32'(exp_addr(base, m, beat)));
      chk("beats_left", 32'(beats_left), 32'(len - beat));
      case (ackp)
        0: mem_ack = 1'b1;
        1: mem_ack = (cyc % 2 == 0);
        default: mem_ack = 1'($urandom_range(0, 1));
      endcase
      if (junk) begin
        load = 1'b1; bus_in = 16'hBEEF; start = 1'b1; len_in = 8'd9;
      end
      step();
      if (mem_ack) beat++;
      cyc++;
      if (cyc > 300) begin
        chk("timeout", 1, 0);
        beat = len;
      end
    end
    mem_ack = 1'b0;
    cur = exp_addr(base, m, len);
    chk("done", 32'(done), 1);
    chk("done_req", 32'(mem_req), 0);
    chk("done_busy", 32'(busy), 1);
    chk("end_addr", 32'(addr_out), 32'(cur));
    chk("end_beats", 32'(beats_left), 0);
    if (junk) begin
      load = 1'b1; bus_in = 16'hBEEF; start = 1'b1; mem_ack = 1'b1;
    end
    step();
    load = 1'b0; start = 1'b0; mem_ack = 1'b0;
    chk("idle_done", 32'(done), 0);
    chk("idle_busy", 32'(busy), 0);
    chk("idle_addr", 32'(addr_out), 32'(cur));
  endtask

  initial begin
    #2 reset = 1'b0;
    #3;
    chk("rst_req", 32'(mem_req), 0);
    chk("rst_addr", 32'(addr_out), 0);
    chk("rst_beats", 32'(beats_left), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    step();
    reset = 1'b1;
    cur = '0;
    step();

    // load 0x1234
    load = 1'b1; bus_in = 16'h1234;
    step();
    load = 1'b0; cur = 16'h1234;
    chk("load1234", 32'(addr_out), 32'h1234);
    chk("load_noreq", 32'(mem_req), 0);

    burst(16'h00FE, 4, 1, 1, 0, 1'b0);   // INC across byte boundary
    burst(16'h123E, 3, 3, 1, 1, 1'b0);   // WRAP with stalls
    burst(16'h0001, 3, 2, 1, 0, 1'b0);   // DEC across zero
    burst(16'h0000, 0, 1, 0, 0, 1'b0);   // zero-length
    burst(16'h0000, 4, 1, 0, 2, 1'b1);   // ignored load/start mid-burst
    burst(16'h0040, 2, 1, 2, 0, 1'b0);   // load+start same cycle
    burst(16'h0000, 3, 0, 0, 2, 1'b0);   // HOLD continuing

    // reset mid-burst: drop it during the 2nd beat of a 5-beat burst
    load = 1'b1; bus_in = 16'h5550;
    step();
    load = 1'b0;
    start = 1'b1; len_in = 8'd5; mode = 2'd1; mem_ack = 1'b1;
    step();
    start = 1'b0;
    step();
    chk("mid_addr", 32'(addr_out), 32'h5551);
    #2 reset = 1'b0;
    #1;
    chk("abort_req", 32'(mem_req), 0);
    chk("abort_busy", 32'(busy), 0);
    chk("abort_addr", 32'(addr_out), 0);
    chk("abort_beats", 32'(beats_left), 0);
    chk("abort_done", 32'(done), 0);
    step();
    chk("abort_done2", 32'(done), 0);
    mem_ack = 1'b0;
    reset = 1'b1;
    cur = '0;
    step();
    chk("post_rst_done", 32'(done), 0);
    burst(16'hFFFE, 5, 1, 1, 0, 1'b0);   // normal after reset, INC wraps

    for (int i = 0; i < 40; i++)
      burst(16'($urandom), $urandom_range(0, 6), $urandom_range(0, 3),
            $urandom_range(0, 2), $urandom_range(0, 2), 1'($urandom_range(0, 1)));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/mem_addr_unit.md
# mem_addr_unit

Parametrised memory address register with a burst sequencer. It holds the current memory address, loads it from the system bus, and steps it automatically through a burst of N accesses. Address stepping is selectable per burst: hold, increment, decrement, or wrap inside an aligned window. It sits between the system bus and the memory port, and drives a req/ack handshake toward memory so the control unit issues one `start` per burst instead of one load per word.

## Interface
- `ADDR_W`, 16, address width and bus width
- `LEN_W`, 8, burst length counter width (max burst 2^LEN_W−1 beats)
- `WIN_W`, 4, low address bits that wrap in WRAP mode (window = 2^WIN_W words); WIN_W < ADDR_W

- `clk`  in  1  clock
- `reset`  in  1  asynchronous, active-low
- `load`  in  1  load `bus_in` into address register (IDLE only)
- `bus_in`  in  ADDR_W  address from system bus
- `len_in`  in  LEN_W  burst length, captured on `start`
- `mode`  in  2  step mode, captured on `start`: 0 HOLD, 1 INC, 2 DEC, 3 WRAP
- `start`  in  1  begin burst (IDLE only)
- `mem_ack`  in  1  memory accepted current beat
- `mem_req`  out  1  beat request, address valid on `addr_out`
- `addr_out`  out  ADDR_W  current address, registered
- `beats_left`  out  LEN_W  beats remaining in burst
- `busy`  out  1  high in REQ and DONE
- `done`  out  1  one-cycle pulse at burst end

## Operation
- States: IDLE, REQ, DONE.
- IDLE:
  - `load`=1 → address ← `bus_in`.
  - `start`=1 → capture `len_in` into `beats_left` and capture `mode`. If `len_in`≠0 go to REQ; if `len_in`=0 go to DONE with no request.
  - `load` and `start` in the same cycle → the load wins for the address, and the burst starts from the newly loaded address.
- REQ: `mem_req`=1.
  - On a clock edge with `mem_ack`=1: address steps per the captured mode and `beats_left` decrements.
  - If `beats_left` was 1, go to DONE; otherwise stay in REQ.
  - `mem_ack`=0 → hold the address and counter, `mem_req` stays high.
- DONE: `done`=1 for exactly one cycle, then IDLE.
- `load` and `start` are ignored outside IDLE. `mem_ack` is ignored outside REQ.
- Stepping, all modulo 2^ADDR_W:
  - HOLD: unchanged.
  - INC: +1, and 0xFFFF wraps to 0x0000.
  - DEC: −1, and 0x0000 wraps to 0xFFFF.
  - WRAP: the low WIN_W bits increment modulo 2^WIN_W; the upper bits are held.
- After a burst, `addr_out` keeps the last stepped address, one step beyond the final beat. A following burst continues from it unless reloaded.

## Timing
- Reset values: address 0, `beats_left` 0, state IDLE, `mem_req` 0, `busy` 0, `done` 0.
- Asynchronous reset mid-burst aborts immediately to reset values. No `done` is produced.
- `start` sampled at edge k → `mem_req` high from after edge k.
- Each beat completes on an edge where `mem_req`&`mem_ack`=1. The new address is visible after that edge, so the minimum is 1 cycle per beat with `mem_ack` held high.
- N-beat burst with `mem_ack` held high: `mem_req` high for N cycles, then `done` in cycle N+1, then IDLE in cycle N+2.
- Zero-length burst: `done` in the cycle after `start`.
- `load` latency: 1 edge. All outputs are registered or decoded from state; there is no combinational path from inputs to outputs.

## Structure
- Package `mem_addr_pkg` holds:
  - the mode encoding constants (HOLD/INC/DEC/WRAP);
  - the state encoding (IDLE/REQ/DONE).
- Sub-module `addr_step`: combinational next-address function (address, mode → next address), parametrised by ADDR_W and WIN_W. It is reused by the program counter.
- The FSM, address register and beat counter live in `mem_addr_unit`.

## Test plan
- Reset/load:
  - Assert `reset`=0 → all outputs 0.
  - Release reset, `load` with `bus_in`=0x1234 → `addr_out`=0x1234 after 1 edge, `mem_req`=0.
- INC burst:
  - Stimulus: addr 0x00FE, `len_in`=4, `mode`=INC, `mem_ack` held 1.
  - Required: addresses 0x00FE, 0x00FF, 0x0100, 0x0101 on successive req cycles.
  - Required: `done` pulse in cycle 5, then `addr_out`=0x0102.
- WRAP with stalls:
  - Stimulus: addr 0x123E, WIN_W=4, `len_in`=3, `mem_ack` toggling 1,0,1,0,1.
  - Required: beats at 0x123E, 0x123F, 0x1230; address held during ack=0 cycles; `done` after the 3rd ack.
- DEC across zero and zero-length burst:
  - DEC from 0x0001 with `len_in`=3 → 0x0001, 0x0000, 0xFFFF.
  - `start` with `len_in`=0 → `done` next cycle, `mem_req` never high.
- Ignored inputs:
  - `load` 0xBEEF and `start` during REQ → no effect on the address sequence or the burst length.
  - Simultaneous `load` 0x0040 + `start` in IDLE → first beat at 0x0040.
- Reset mid-burst:
  - Drop `reset` in the 2nd beat of a 5-beat burst → `mem_req`, `busy`, `addr_out` and `beats_left` go to 0 immediately; no `done`.
  - Next burst after reset operates normally.
